shift_ex_stage: RTL and testbench
=================================

Name: shift_ex_stage

Overview:
- Execute-stage front end for MIPS R-type shift instructions (sll, srl, sra, sllv, srlv, srav) in the multicycle/pipelined CPU.
- Accepts decoded operands from the ID stage over a valid/ready handshake and registers them.
- Drives the combinational shifter's A/B/Shiftop inputs from that register, captures the shifter result, and hands it to MEM/WB through a second valid/ready register with backpressure and flush.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- SHAMT_WIDTH, 5, shift-amount field width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  ID has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_funct  input  6  R-type funct field.
- in_shamt  input  5  instruction shamt field.
- in_rs_val  input  32  rs operand.
- in_rt_val  input  32  rt operand.
- in_rd  input  5  destination register.
- in_pc  input  32  instruction PC.
- sh_A  output  32  to shifter A.
- sh_B  output  32  to shifter B.
- sh_Shiftop  output  2  to shifter Shiftop.
- sh_Result  input  32  from shifter Result.
- out_valid  output  1  result available.
- out_ready  input  1  MEM/WB accepts.
- out_result  output  32  shifted value.
- out_rd  output  5  write-back register.
- out_wen  output  1  register-file write enable.
- out_illegal  output  1  funct was not a shift.
- out_pc  output  32  PC of the result.

Behaviour:
- Two registers:
  - EX register: ex_valid, funct, shamt, rs, rt, rd, pc.
  - OUT register: out_valid, result, rd, wen, illegal, pc.
- Reset (rst low, asynchronous) clears every register to 0:
  - out_valid=0, out_result=0, out_rd=0, out_wen=0, out_illegal=0, out_pc=0.
  - sh_A=0, sh_B=0, sh_Shiftop=2'b00.
  - in_ready rises once rst deasserts.
- Handshakes:
  - ex_advance = ex_valid & (~out_valid | out_ready).
  - in_ready = ~flush & (~ex_valid | ex_advance).
  - A transfer occurs when in_valid & in_ready.
- EX register: loads on an input transfer. Otherwise, ex_valid clears on ex_advance.
- Decode from the EX register (combinational into the shifter):
  - 000000 sll: A=rt, B=zext(shamt), op=00.
  - 000010 srl: A=rt, B=zext(shamt), op=10.
  - 000011 sra: A=rt, B=zext(shamt), op=11.
  - 000100 sllv: A=rt, B=zext(rs[4:0]), op=00.
  - 000110 srlv: A=rt, B=zext(rs[4:0]), op=10.
  - 000111 srav: A=rt, B=zext(rs[4:0]), op=11.
  - Any other funct: op=01 (pass A), B=0, illegal=1.
- B width rule: B is always zero-extended from 5 bits, so upper rs bits never reach the shifter. A shift by 32+ cannot occur.
- OUT register:
  - On ex_advance: captures sh_Result, rd, pc, illegal; wen = ~illegal & (rd != 0).
  - Else if out_ready: out_valid clears.
- Latency and throughput:
  - Input transfer at edge N gives out_valid=1 after edge N+1.
  - Throughput is 1 instruction per cycle while out_ready=1.
- Backpressure:
  - out_valid & ~out_ready holds OUT stable. EX also holds if full, and in_ready=0.
  - Stage capacity is 2 instructions.
  - When out_ready rises, OUT drains and EX advances in the same edge.
  - When EX empties while OUT drains, in_ready=1 that cycle.
- Simultaneous events: a new input accepted in the same edge EX advances is legal. EX takes the new instruction and OUT takes the old one.
- Flush (synchronous):
  - Clears ex_valid and out_valid at the edge. in_ready=0 during flush, so no transfer.
  - Flush has priority over advance and accept. Data fields may keep stale values.
- Reset mid-operation: in-flight instructions are discarded immediately. out_valid drops asynchronously.
- OUT data is stable whenever out_valid=1 and out_ready=0.

Test Plan:
- sll, rt=0x0000_0001, shamt=31 -> after 2 edges out_result=0x8000_0000, wen=1, Shiftop seen=00, B=31.
- srav, rt=0x8000_00F0, rs=0xFFFF_FFE4 -> B=4, out_result=0xF800_000F. Upper rs bits are ignored.
- Back-to-back srl/sra with out_ready held low 3 cycles:
  - in_ready drops after 2 accepts.
  - OUT stays stable.
  - On release, both results emerge in order on consecutive cycles with no loss or duplication.
- funct=0x20 (add), rt=0x1234_5678 -> out_result=0x1234_5678, out_illegal=1, out_wen=0.
- sll with rd=0 -> out_wen=0. Flush asserted with both registers full -> next cycle out_valid=0 and nothing emitted.
- rst pulled low while out_valid=1 mid-stall -> out_valid=0 immediately. After release, in_ready=1 and all outputs are 0.

Source files
------------

// File: rtl/shift_ex_stage.sv
// Execute-stage front end for R-type shifts (sll/srl/sra/sllv/srlv/srav).
// The EX register feeds an external combinational shifter. The OUT register
// captures the shifter result and presents it to MEM/WB through a valid/ready
// handshake that supports backpressure and flush.
module shift_ex_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             in_funct,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [DATA_WIDTH-1:0]  in_rs_val,
  input  logic [DATA_WIDTH-1:0]  in_rt_val,
  input  logic [4:0]             in_rd,
  input  logic [DATA_WIDTH-1:0]  in_pc,
  output logic [DATA_WIDTH-1:0]  sh_A,
  output logic [DATA_WIDTH-1:0]  sh_B,
  output logic [1:0]             sh_Shiftop,
  input  logic [DATA_WIDTH-1:0]  sh_Result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_result,
  output logic [4:0]             out_rd,
  output logic                   out_wen,
  output logic                   out_illegal,
  output logic [DATA_WIDTH-1:0]  out_pc
);

  typedef struct packed {
    logic [1:0]             op;
    logic [SHAMT_WIDTH-1:0] amt;
    logic                   illegal;
  } dec_t;

  // Shiftop encoding seen by the shifter: 00 sll, 01 pass A, 10 srl, 11 sra.
  function automatic dec_t decode(input logic [5:0]             funct,
                                  input logic [SHAMT_WIDTH-1:0] shamt,
                                  input logic [SHAMT_WIDTH-1:0] rs_amt);
    dec_t d;
    d = '{op: 2'b01, amt: '0, illegal: 1'b1};
    case (funct)
      6'b000000: d = '{op: 2'b00, amt: shamt,  illegal: 1'b0};
      6'b000010: d = '{op: 2'b10, amt: shamt,  illegal: 1'b0};
      6'b000011: d = '{op: 2'b11, amt: shamt,  illegal: 1'b0};
      6'b000100: d = '{op: 2'b00, amt: rs_amt, illegal: 1'b0};
      6'b000110: d = '{op: 2'b10, amt: rs_amt, illegal: 1'b0};
      6'b000111: d = '{op: 2'b11, amt: rs_amt, illegal: 1'b0};
      default:   d = '{op: 2'b01, amt: '0,     illegal: 1'b1};
    endcase
    return d;
  endfunction

  // EX register (stage p0). Only the low rs bits are kept: variable shifts
  // use rs[4:0] and nothing else of rs is consumed downstream.
  logic                   vld_p0;
  logic [5:0]             funct_p0;
  logic [SHAMT_WIDTH-1:0] shamt_p0;
  logic [SHAMT_WIDTH-1:0] rs_amt_p0;
  logic [DATA_WIDTH-1:0]  rt_p0;
  logic [4:0]             rd_p0;
  logic [DATA_WIDTH-1:0]  pc_p0;

  // OUT register (stage p1).
  logic                   vld_p1;
  logic [DATA_WIDTH-1:0]  result_p1;
  logic [4:0]             rd_p1;
  logic                   wen_p1;
  logic                   illegal_p1;
  logic [DATA_WIDTH-1:0]  pc_p1;

  logic ex_advance;
  logic in_xfer;
  dec_t dec;
  logic unused_rs_hi;

  assign unused_rs_hi = ^in_rs_val[DATA_WIDTH-1:SHAMT_WIDTH];

  assign ex_advance = vld_p0 & (~vld_p1 | out_ready);
  assign in_ready   = ~flush & (~vld_p0 | ex_advance);
  assign in_xfer    = in_valid & in_ready;

  // ---- stage p0 boundary: accept from ID ----
  // Load on transfer; otherwise drain when the instruction moves to OUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0    <= 1'b0;
      funct_p0  <= '0;
      shamt_p0  <= '0;
      rs_amt_p0 <= '0;
      rt_p0     <= '0;
      rd_p0     <= '0;
      pc_p0     <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (in_xfer) begin
      vld_p0    <= 1'b1;
      funct_p0  <= in_funct;
      shamt_p0  <= in_shamt;
      rs_amt_p0 <= in_rs_val[SHAMT_WIDTH-1:0];
      rt_p0     <= in_rt_val;
      rd_p0     <= in_rd;
      pc_p0     <= in_pc;
    end else if (ex_advance) begin
      vld_p0 <= 1'b0;
    end
  end

  // Combinational decode of the EX register into the shifter inputs.
  always_comb begin
    dec        = decode(funct_p0, shamt_p0, rs_amt_p0);
    sh_A       = rt_p0;
    sh_B       = {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, dec.amt};
    sh_Shiftop = dec.op;
  end

  // ---- stage p1 boundary: capture shifter result for MEM/WB ----
  // Capture on advance; otherwise drop valid once MEM/WB has taken it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      rd_p1      <= '0;
      wen_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      pc_p1      <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (ex_advance) begin
      vld_p1     <= 1'b1;
      result_p1  <= sh_Result;
      rd_p1      <= rd_p0;
      wen_p1     <= ~dec.illegal & (rd_p0 != 5'd0);
      illegal_p1 <= dec.illegal;
      pc_p1      <= pc_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_result  = result_p1;
  assign out_rd      = rd_p1;
  assign out_wen     = wen_p1;
  assign out_illegal = illegal_p1;
  assign out_pc      = pc_p1;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: a behavioural shifter closes the loop, a
// reference model fills a scoreboard queue on each accepted instruction, and
// a negedge monitor compares every result MEM/WB takes.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic [31:0] sh_A;
  logic [31:0] sh_B;
  logic [1:0]  sh_Shiftop;
  logic [31:0] sh_Result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic [31:0] out_pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  shift_ex_stage #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_rd(in_rd), .in_pc(in_pc),
    .sh_A(sh_A), .sh_B(sh_B), .sh_Shiftop(sh_Shiftop), .sh_Result(sh_Result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // External shifter: 00 sll, 01 pass A, 10 srl, 11 sra.
  always_comb begin
    case (sh_Shiftop)
      2'b00:   sh_Result = sh_A << sh_B;
      2'b01:   sh_Result = sh_A;
      2'b10:   sh_Result = sh_A >> sh_B;
      default: sh_Result = $unsigned($signed(sh_A) >>> sh_B);
    endcase
  end

  function automatic exp_t model(input logic [5:0] f, input logic [4:0] shamt,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] rd, input logic [31:0] pc);
    exp_t e;
    e.illegal = 1'b0;
    case (f)
      6'h00:   e.result = rt << shamt;
      6'h02:   e.result = rt >> shamt;
      6'h03:   e.result = $unsigned($signed(rt) >>> shamt);
      6'h04:   e.result = rt << rs[4:0];
      6'h06:   e.result = rt >> rs[4:0];
      6'h07:   e.result = $unsigned($signed(rt) >>> rs[4:0]);
      default: begin e.result = rt; e.illegal = 1'b1; end
    endcase
    e.rd  = rd;
    e.wen = !e.illegal && (rd != 5'd0);
    e.pc  = pc;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_result",  out_result,  e.result);
          check("sb_rd",      out_rd,      e.rd);
          check("sb_wen",     out_wen,     e.wen);
          check("sb_illegal", out_illegal, e.illegal);
          check("sb_pc",      out_pc,      e.pc);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_funct, in_shamt, in_rs_val, in_rt_val, in_rd, in_pc));
    end
  end

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [5:0] f, input logic [4:0] shamt,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] rd, input logic [31:0] pc, output int waited);
    in_valid = 1'b1; in_funct = f; in_shamt = shamt;
    in_rs_val = rs; in_rt_val = rt; in_rd = rd; in_pc = pc;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] held_res;
    logic [5:0]  fl [6];
    fl[0] = 6'h00; fl[1] = 6'h02; fl[2] = 6'h03;
    fl[3] = 6'h04; fl[4] = 6'h06; fl[5] = 6'h07;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_shamt = '0; in_rs_val = '0; in_rt_val = '0; in_rd = '0; in_pc = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid",   out_valid,   0);
    check("rst_out_result",  out_result,  0);
    check("rst_out_rd",      out_rd,      0);
    check("rst_out_wen",     out_wen,     0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_out_pc",      out_pc,      0);
    check("rst_sh_A",        sh_A,        0);
    check("rst_sh_B",        sh_B,        0);
    check("rst_sh_op",       sh_Shiftop,  0);
    tick(); tick();
    rst = 1'b1;
    #1 check("rst_release_in_ready", in_ready, 1);

    // sll rt=1 by 31
    out_ready = 1'b1;
    send(6'h00, 5'd31, 32'h0, 32'h0000_0001, 5'd9, 32'h0000_0100, w);
    check("sll_sh_A",  sh_A,       32'h1);
    check("sll_sh_B",  sh_B,       32'd31);
    check("sll_sh_op", sh_Shiftop, 2'b00);
    tick();
    check("sll_out_valid",  out_valid,  1);
    check("sll_out_result", out_result, 32'h8000_0000);
    check("sll_out_wen",    out_wen,    1);

    // srav with junk in upper rs bits
    send(6'h07, 5'd0, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd10, 32'h0000_0104, w);
    check("srav_sh_B",  sh_B,       32'd4);
    check("srav_sh_op", sh_Shiftop, 2'b11);
    tick();
    check("srav_out_result", out_result, 32'hF800_000F);
    tick();

    // Backpressure: srl then sra with out_ready low for 3 cycles
    out_ready = 1'b0;
    send(6'h02, 5'd4, 32'h0, 32'hF000_0000, 5'd3, 32'h0000_0200, w);
    send(6'h03, 5'd8, 32'h0, 32'h8000_0000, 5'd4, 32'h0000_0204, w);
    check("bp_in_ready_full", in_ready,  0);
    check("bp_out_valid",     out_valid, 1);
    held_res = out_result;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid",    out_valid,  1);
      check("bp_hold_result",   out_result, held_res);
      check("bp_hold_in_ready", in_ready,   0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_second_valid",  out_valid,  1);
    check("bp_second_result", out_result, 32'hFF80_0000);
    tick();
    check("bp_drained", out_valid, 0);

    // Illegal funct (add) passes rt through without write-back
    send(6'h20, 5'd0, 32'h0, 32'h1234_5678, 5'd5, 32'h0000_0300, w);
    check("illegal_sh_op", sh_Shiftop, 2'b01);
    tick();
    check("illegal_result", out_result,  32'h1234_5678);
    check("illegal_flag",   out_illegal, 1);
    check("illegal_wen",    out_wen,     0);

    // sll to $zero never writes
    send(6'h00, 5'd3, 32'h0, 32'h0000_0011, 5'd0, 32'h0000_0304, w);
    tick();
    check("rd0_wen", out_wen, 0);
    tick();

    // Throughput: random shifts, each accepted without waiting
    for (int i = 0; i < 8; i++) begin
      send(fl[$urandom_range(0, 5)], 5'($urandom), $urandom, $urandom,
           5'($urandom), 32'h400 + 32'(i * 4), w);
      check("tput_no_wait", w, 0);
    end
    tick(); tick();

    // Flush with both registers full
    out_ready = 1'b0;
    send(6'h00, 5'd1, 32'h0, 32'h1, 5'd6, 32'h0000_0500, w);
    send(6'h02, 5'd1, 32'h0, 32'h2, 5'd7, 32'h0000_0504, w);
    check("flush_pre_valid", out_valid, 1);
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_nothing", out_valid, 0);
    end

    // Reset during a stall
    out_ready = 1'b0;
    send(6'h00, 5'd2, 32'h0, 32'h5, 5'd8, 32'h0000_0600, w);
    tick();
    check("midrst_pre_valid", out_valid, 1);
    rst = 1'b0;
    #1 check("midrst_async_valid", out_valid, 0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready,    1);
    check("midrst_result",   out_result,  0);
    check("midrst_rd",       out_rd,      0);
    check("midrst_wen",      out_wen,     0);
    check("midrst_illegal",  out_illegal, 0);
    check("midrst_pc",       out_pc,      0);
    check("midrst_sh_A",     sh_A,        0);
    check("midrst_sh_B",     sh_B,        0);
    check("midrst_sh_op",    sh_Shiftop,  0);

    out_ready = 1'b1;
    repeat (3) tick();
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
